// File: rtl/bus_arbiter_2to1_if.sv
// Handshake bundle between two requesters, the 2:1 arbiter and the downstream consumer.
// The slave modport is the arbiter's view. The master modport is the requester/consumer side.
interface bus_arbiter_2to1_if #(
    parameter int WIDTH = 16
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_data;
    logic             req0_last;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_data;
    logic             req1_last;
    logic             req1_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;

    modport master (
        output req0_valid, req0_data, req0_last,
        input  req0_ready,
        output req1_valid, req1_data, req1_last,
        input  req1_ready,
        input  out_valid, out_data,
        output out_ready
    );

    modport slave (
        input  req0_valid, req0_data, req0_last,
        output req0_ready,
        input  req1_valid, req1_data, req1_last,
        output req1_ready,
        output out_valid, out_data,
        input  out_ready
    );
endinterface

// File: rtl/bus_arbiter_2to1.sv
// Round-robin 2:1 burst arbiter. It holds the grant until a last beat or until MAX_BEATS beats.
// The selected beat is registered into a single valid/ready output stage.
module bus_arbiter_2to1 #(
    parameter int WIDTH     = 16,
    parameter int MAX_BEATS = 8
) (
    input  logic               clk,
    input  logic               reset,
    bus_arbiter_2to1_if.slave  bus,
    output logic               sel,
    output logic [1:0]         grant,
    output logic               burst_trunc
);
    localparam int CNT_W = $clog2(MAX_BEATS + 1);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e           state_q, state_d;
    logic             sel_q, sel_d;
    logic             prio_q, prio_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             burst_trunc_q, burst_trunc_d;

    logic             slot_free;
    logic             own_valid;
    logic             own_last;
    logic [WIDTH-1:0] own_data;
    logic             cnt_full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            sel_q         <= 1'b0;
            prio_q        <= 1'b0;
            beat_cnt_q    <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            burst_trunc_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            prio_q        <= prio_d;
            beat_cnt_q    <= beat_cnt_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            burst_trunc_q <= burst_trunc_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        sel_d          = sel_q;
        prio_d         = prio_q;
        beat_cnt_d     = beat_cnt_q;
        out_valid_d    = out_valid_q;
        out_data_d     = out_data_q;
        burst_trunc_d  = 1'b0;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;

        // The output register can take a new beat when it is empty or draining this cycle.
        slot_free = !out_valid_q || bus.out_ready;
        own_valid = sel_q ? bus.req1_valid : bus.req0_valid;
        own_last  = sel_q ? bus.req1_last  : bus.req0_last;
        own_data  = sel_q ? bus.req1_data  : bus.req0_data;
        cnt_full  = (beat_cnt_q == CNT_W'(MAX_BEATS - 1));

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (bus.req0_valid || bus.req1_valid) begin
                    sel_d      = (bus.req0_valid && bus.req1_valid) ? prio_q : bus.req1_valid;
                    state_d    = BUSY;
                    beat_cnt_d = '0;
                end
            end
            BUSY: begin
                bus.req0_ready = !sel_q && slot_free;
                bus.req1_ready = sel_q && slot_free;
                if (own_valid && slot_free) begin
                    out_valid_d = 1'b1;
                    out_data_d  = own_data;
                    beat_cnt_d  = beat_cnt_q + 1'b1;
                    if (own_last || cnt_full) begin
                        state_d       = IDLE;
                        prio_d        = !sel_q;
                        beat_cnt_d    = '0;
                        burst_trunc_d = !own_last;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // sel keeps the last owner through IDLE so the mux does not glitch between bursts.
    assign sel           = sel_q;
    assign grant         = (state_q == BUSY) ? (sel_q ? 2'b10 : 2'b01) : 2'b00;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign burst_trunc   = burst_trunc_q;
endmodule

// File: tb/tb_bus_arbiter_2to1.sv
// Randomized bench for bus_arbiter_2to1. Per-requester source queues feed a
// burst-level reference that predicts grant/ready and the expected output stream.
module tb_bus_arbiter_2to1;
    localparam int WIDTH     = 16;
    localparam int MAX_BEATS = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       sel;
    logic [1:0] grant;
    logic       burst_trunc;

    bus_arbiter_2to1_if #(.WIDTH(WIDTH)) bus ();

    bus_arbiter_2to1 #(.WIDTH(WIDTH), .MAX_BEATS(MAX_BEATS)) dut (
        .clk        (clk),
        .reset      (rst),
        .bus        (bus),
        .sel        (sel),
        .grant      (grant),
        .burst_trunc(burst_trunc)
    );

    always #5 clk = ~clk;

    // Driven stimulus
    logic [1:0]       drv_v;
    logic [WIDTH-1:0] drv_d0, drv_d1;
    logic             drv_l0, drv_l1;
    logic             drv_or;

    assign bus.req0_valid = drv_v[0];
    assign bus.req0_data  = drv_d0;
    assign bus.req0_last  = drv_l0;
    assign bus.req1_valid = drv_v[1];
    assign bus.req1_data  = drv_d1;
    assign bus.req1_last  = drv_l1;
    assign bus.out_ready  = drv_or;

    // Sources: {last, data} beats waiting to be offered by each requester
    logic [WIDTH:0]   src0_q[$];
    logic [WIDTH:0]   src1_q[$];
    logic [WIDTH-1:0] exp_q[$];

    // Reference: who owns the bus, rotating priority, beats granted so far
    bit          m_busy, m_owner, m_prio, m_trunc;
    int unsigned m_cnt;

    int unsigned p_valid, p_ready, stall_cnt;
    int unsigned trunc_seen, beats_out;
    int unsigned n_cmp = 0, n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void push_beats(input int who, input int unsigned len, input bit with_last);
        logic [WIDTH:0] it;
        for (int unsigned i = 0; i < len; i++) begin
            it = {1'(with_last && (i == len - 1)), WIDTH'($urandom)};
            if (who == 0) src0_q.push_back(it);
            else          src1_q.push_back(it);
        end
    endfunction

    function automatic void model_reset();
        m_busy  = 1'b0;
        m_owner = 1'b0;
        m_prio  = 1'b0;
        m_cnt   = 0;
        m_trunc = 1'b0;
        exp_q.delete();
    endfunction

    // Advance the reference by one clock edge using the values that were driven before the edge.
    function automatic void model_edge();
        bit             acc;
        bit             own_v;
        logic [WIDTH:0] it;
        if (rst) return;
        m_trunc = 1'b0;
        acc     = 1'b0;
        if (m_busy) begin
            own_v = m_owner ? drv_v[1] : drv_v[0];
            acc   = own_v && (exp_q.size() == 0 || drv_or);
        end
        if (exp_q.size() != 0 && drv_or) void'(exp_q.pop_front());
        if (!m_busy) begin
            if (drv_v != 2'b00) begin
                m_owner = (drv_v == 2'b11) ? m_prio : drv_v[1];
                m_busy  = 1'b1;
                m_cnt   = 0;
            end
        end else if (acc) begin
            it = m_owner ? src1_q.pop_front() : src0_q.pop_front();
            exp_q.push_back(it[WIDTH-1:0]);
            if (it[WIDTH] || m_cnt == MAX_BEATS - 1) begin
                m_busy  = 1'b0;
                m_prio  = !m_owner;
                m_trunc = !it[WIDTH];
                m_cnt   = 0;
            end else begin
                m_cnt++;
            end
        end
    endfunction

    task automatic drive();
        logic [WIDTH:0] h;
        drv_v[0] = (src0_q.size() != 0) && ($urandom_range(99) < p_valid);
        drv_v[1] = (src1_q.size() != 0) && ($urandom_range(99) < p_valid);
        h = (src0_q.size() != 0) ? src0_q[0] : (WIDTH+1)'($urandom);
        drv_d0 = h[WIDTH-1:0];
        drv_l0 = h[WIDTH];
        h = (src1_q.size() != 0) ? src1_q[0] : (WIDTH+1)'($urandom);
        drv_d1 = h[WIDTH-1:0];
        drv_l1 = h[WIDTH];
        if (stall_cnt > 0) begin
            drv_or = 1'b0;
            stall_cnt--;
        end else begin
            drv_or = ($urandom_range(99) < p_ready);
        end
    endtask

    task automatic check_outputs();
        bit mv;
        bit slot;
        mv   = (exp_q.size() != 0);
        slot = !mv || drv_or;
        check_eq("grant", 32'(grant), m_busy ? (m_owner ? 32'd2 : 32'd1) : 32'd0);
        check_eq("sel", 32'(sel), 32'(m_owner));
        check_eq("ready0", 32'(bus.req0_ready), 32'(m_busy && !m_owner && slot));
        check_eq("ready1", 32'(bus.req1_ready), 32'(m_busy && m_owner && slot));
        check_eq("out_valid", 32'(bus.out_valid), 32'(mv));
        if (mv) check_eq("out_data", 32'(bus.out_data), 32'(exp_q[0]));
        check_eq("burst_trunc", 32'(burst_trunc), 32'(m_trunc));
        if (burst_trunc) trunc_seen++;
        if (bus.out_valid && drv_or) beats_out++;
    endtask

    task automatic run(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge clk);
            check_outputs();
            @(posedge clk);
            model_edge();
            #1;
            drive();
        end
    endtask

    initial begin
        int first_ov;
        int unsigned guard;
        rst       = 1'b1;
        drv_v     = 2'b00;
        drv_d0    = '0;
        drv_d1    = '0;
        drv_l0    = 1'b0;
        drv_l1    = 1'b0;
        drv_or    = 1'b0;
        stall_cnt = 0;
        p_valid   = 100;
        p_ready   = 100;
        model_reset();

        // Reset values
        @(negedge clk);
        check_outputs();

        // Single 3-beat burst from requester 0: grant at N+1, first out beat at N+2
        push_beats(0, 3, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive();
        first_ov = -1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check_outputs();
            if (bus.out_valid && first_ov < 0) first_ov = k;
            @(posedge clk);
            model_edge();
            #1;
            drive();
        end
        check_eq("latency", 32'(first_ov), 32'd2);

        // Both requesters busy: bursts alternate at burst boundaries
        for (int b = 0; b < 4; b++) begin
            push_beats(0, $urandom_range(1, 4), 1'b1);
            push_beats(1, $urandom_range(1, 4), 1'b1);
        end
        run(60);

        // Consumer stalls for 3 cycles in the middle of a burst
        push_beats(0, 6, 1'b1);
        run(3);
        stall_cnt = 3;
        run(20);

        // Let everything drain before the truncation case
        guard = 0;
        while ((src0_q.size() != 0 || src1_q.size() != 0 || exp_q.size() != 0 || m_busy) && guard < 200) begin
            run(1);
            guard++;
        end
        check_eq("drain", 32'(src0_q.size() + src1_q.size() + exp_q.size()), 32'd0);

        // 10 beats without last: forced release after MAX_BEATS, rest on regrant
        trunc_seen = 0;
        beats_out  = 0;
        push_beats(1, 10, 1'b0);
        run(40);
        check_eq("trunc_cnt", trunc_seen, 32'd1);
        check_eq("trunc_beats", beats_out, 32'd10);

        // Asynchronous reset while a beat sits in the output stage
        push_beats(1, 5, 1'b0);
        p_ready = 0;
        guard   = 0;
        while (!(m_busy && exp_q.size() != 0) && guard < 100) begin
            run(1);
            guard++;
        end
        check_eq("busy_with_beat", 32'(bus.out_valid), 32'd1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("rst_grant", 32'(grant), 32'd0);
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_sel", 32'(sel), 32'd0);
        check_eq("rst_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
        model_reset();
        @(posedge clk);
        model_edge();
        #1;
        rst     = 1'b0;
        p_valid = 70;
        p_ready = 70;
        drive();

        // Random traffic
        for (int unsigned c = 0; c < 10000; c++) begin
            if (src0_q.size() < 2) push_beats(0, $urandom_range(1, 10), 1'($urandom_range(9) < 8));
            if (src1_q.size() < 2) push_beats(1, $urandom_range(1, 10), 1'($urandom_range(9) < 8));
            run(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
